llc_trace_stats: RTL and testbench

//  Synthesizable, parametrised statistics engine for the LLC trace flow; replaces bench-side real-valued stats.

---
 rtl/llc_trace_stats.sv | 231 +++++++++++++++++++++++
 tb/tb_llc_trace_stats.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/llc_trace_stats.sv
// LLC trace statistics engine: per-channel saturating read/write/hit/miss counters
// with a snapshot report and a sequential restoring divider for the fixed-point hit ratio.

module llc_trace_ch #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc_rd,
    input  logic             inc_wr,
    input  logic             inc_hit,
    input  logic             inc_miss,
    output logic [CNT_W-1:0] rd,
    output logic [CNT_W-1:0] wr,
    output logic [CNT_W-1:0] hit,
    output logic [CNT_W-1:0] miss
);
    logic [CNT_W-1:0] rd_q, rd_d, wr_q, wr_d, hit_q, hit_d, miss_q, miss_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        rd_d   = sat_inc(rd_q, inc_rd);
        wr_d   = sat_inc(wr_q, inc_wr);
        hit_d  = sat_inc(hit_q, inc_hit);
        miss_d = sat_inc(miss_q, inc_miss);
        if (clr) begin
            rd_d   = '0;
            wr_d   = '0;
            hit_d  = '0;
            miss_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign rd   = rd_q;
    assign wr   = wr_q;
    assign hit  = hit_q;
    assign miss = miss_q;
endmodule

module llc_trace_stats #(
    parameter int NUM_CH = 2,
    parameter int CMD_W  = 4,
    parameter int CNT_W  = 32,
    parameter int FRAC_W = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic [CH_W-1:0]   ev_ch,
    input  logic [CMD_W-1:0]  ev_cmd,
    input  logic              ev_hit,
    input  logic              rpt_req,
    input  logic [CH_W-1:0]   rpt_ch,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [CNT_W-1:0]  rpt_reads,
    output logic [CNT_W-1:0]  rpt_writes,
    output logic [CNT_W-1:0]  rpt_hits,
    output logic [CNT_W-1:0]  rpt_misses,
    output logic [FRAC_W:0]   rpt_ratio
);
    localparam int DC_W = $clog2(FRAC_W + 1);

    typedef enum logic [1:0] {IDLE, SNAP, DIV, DONE} state_t;

    state_t                       state_q, state_d;
    logic [CH_W-1:0]              rch_q, rch_d;
    logic [CNT_W-1:0]             s_rd_q, s_rd_d, s_wr_q, s_wr_d, s_hit_q, s_hit_d, s_miss_q, s_miss_d;
    logic [CNT_W:0]               total_q, total_d;
    logic [CNT_W+1:0]             rem_q, rem_d, trial;
    logic [FRAC_W:0]              quo_q, quo_d;
    logic [DC_W-1:0]              dcnt_q, dcnt_d;
    logic                         rpt_valid_q, rpt_valid_d;
    logic                         qbit;

    logic [NUM_CH-1:0][CNT_W-1:0] c_rd, c_wr, c_hit, c_miss;
    logic [NUM_CH-1:0]            ch_sel;
    logic [CNT_W-1:0]             l_rd, l_wr, l_hit, l_miss;
    logic [CNT_W:0]               l_total;
    logic                         acc, ev_ok, rch_ok, is_rd, is_wr, is_rw, is_clr, is_rpt, trig;

    assign ev_ready = (state_q == IDLE);
    assign acc      = ev_valid && ev_ready;
    assign ev_ok    = 32'(ev_ch) < NUM_CH;
    assign rch_ok   = 32'(rch_q) < NUM_CH;
    assign is_rd    = (ev_cmd == CMD_W'(0)) || (ev_cmd == CMD_W'(2));
    assign is_wr    = (ev_cmd == CMD_W'(1));
    assign is_rw    = is_rd || is_wr;
    assign is_clr   = (ev_cmd == CMD_W'(8));
    assign is_rpt   = (ev_cmd == CMD_W'(9)) && !mode;
    // rpt_req alone is enough to trigger; an event only triggers if it lands on a real channel
    assign trig     = ev_ready && (rpt_req || (acc && ev_ok && is_rpt));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_sel[i] = acc && ev_ok && (ev_ch == CH_W'(i));
        llc_trace_ch #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .clr      (ch_sel[i] && is_clr),
            .inc_rd   (ch_sel[i] && is_rd),
            .inc_wr   (ch_sel[i] && is_wr),
            .inc_hit  (ch_sel[i] && is_rw && ev_hit),
            .inc_miss (ch_sel[i] && is_rw && !ev_hit),
            .rd       (c_rd[i]),
            .wr       (c_wr[i]),
            .hit      (c_hit[i]),
            .miss     (c_miss[i])
        );
    end

    always_comb begin
        l_rd   = '0;
        l_wr   = '0;
        l_hit  = '0;
        l_miss = '0;
        if (rch_ok) begin
            l_rd   = c_rd[rch_q];
            l_wr   = c_wr[rch_q];
            l_hit  = c_hit[rch_q];
            l_miss = c_miss[rch_q];
        end
        l_total = {1'b0, l_hit} + {1'b0, l_miss};
    end

    always_comb begin
        state_d     = state_q;
        rch_d       = rch_q;
        s_rd_d      = s_rd_q;
        s_wr_d      = s_wr_q;
        s_hit_d     = s_hit_q;
        s_miss_d    = s_miss_q;
        total_d     = total_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dcnt_d      = dcnt_q;
        rpt_valid_d = 1'b0;
        // first step tests the unshifted hits for the integer bit (ratio can reach 1.0)
        trial       = (dcnt_q == '0) ? rem_q : {rem_q[CNT_W:0], 1'b0};
        qbit        = trial >= {1'b0, total_q};
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = SNAP;
                    rch_d   = rpt_req ? rpt_ch : ev_ch;
                end
            end
            SNAP: begin
                s_rd_d   = l_rd;
                s_wr_d   = l_wr;
                s_hit_d  = l_hit;
                s_miss_d = l_miss;
                total_d  = l_total;
                rem_d    = {2'b00, l_hit};
                quo_d    = '0;
                dcnt_d   = '0;
                state_d  = (l_total == '0) ? DONE : DIV;
            end
            DIV: begin
                rem_d  = qbit ? trial - {1'b0, total_q} : trial;
                quo_d  = {quo_q[FRAC_W-1:0], qbit};
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DC_W'(FRAC_W))
                    state_d = DONE;
            end
            DONE: begin
                rpt_valid_d = 1'b1;
                if (rpt_valid_q && rpt_ready) begin
                    rpt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rch_q       <= '0;
            s_rd_q      <= '0;
            s_wr_q      <= '0;
            s_hit_q     <= '0;
            s_miss_q    <= '0;
            total_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dcnt_q      <= '0;
            rpt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rch_q       <= rch_d;
            s_rd_q      <= s_rd_d;
            s_wr_q      <= s_wr_d;
            s_hit_q     <= s_hit_d;
            s_miss_q    <= s_miss_d;
            total_q     <= total_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dcnt_q      <= dcnt_d;
            rpt_valid_q <= rpt_valid_d;
        end
    end

    assign rpt_valid  = rpt_valid_q;
    assign rpt_reads  = s_rd_q;
    assign rpt_writes = s_wr_q;
    assign rpt_hits   = s_hit_q;
    assign rpt_misses = s_miss_q;
    assign rpt_ratio  = quo_q;
endmodule

// File: tb/tb_llc_trace_stats.sv
// Bench for llc_trace_stats: directed scenarios then random traffic against an
// array-based counter model; report contents and latency come from the model.

module tb_llc_trace_stats;
    localparam int NUM_CH = 3;
    localparam int CMD_W  = 4;
    localparam int CNT_W  = 4;
    localparam int FRAC_W = 8;
    localparam int CH_W   = 2;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              clk = 1'b0, rst = 1'b1, mode = 1'b0;
    logic              ev_valid = 1'b0, ev_ready, ev_hit = 1'b0;
    logic [CH_W-1:0]   ev_ch = '0, rpt_ch = '0;
    logic [CMD_W-1:0]  ev_cmd = '0;
    logic              rpt_req = 1'b0, rpt_valid, rpt_ready = 1'b0;
    logic [CNT_W-1:0]  rpt_reads, rpt_writes, rpt_hits, rpt_misses;
    logic [FRAC_W:0]   rpt_ratio;

    llc_trace_stats #(.NUM_CH(NUM_CH), .CMD_W(CMD_W), .CNT_W(CNT_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_ch(ev_ch), .ev_cmd(ev_cmd), .ev_hit(ev_hit), .rpt_req(rpt_req), .rpt_ch(rpt_ch),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_reads(rpt_reads),
        .rpt_writes(rpt_writes), .rpt_hits(rpt_hits), .rpt_misses(rpt_misses),
        .rpt_ratio(rpt_ratio)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int m_rd[NUM_CH], m_wr[NUM_CH], m_hit[NUM_CH], m_miss[NUM_CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat1(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic model_clear_all();
        for (int i = 0; i < NUM_CH; i++) begin
            m_rd[i] = 0; m_wr[i] = 0; m_hit[i] = 0; m_miss[i] = 0;
        end
    endtask

    task automatic model_ev(input int ch, input int cmd, input bit hit);
        if (ch >= NUM_CH) return;
        if (cmd == 0 || cmd == 2) m_rd[ch] = sat1(m_rd[ch]);
        if (cmd == 1)             m_wr[ch] = sat1(m_wr[ch]);
        if (cmd <= 2) begin
            if (hit) m_hit[ch]  = sat1(m_hit[ch]);
            else     m_miss[ch] = sat1(m_miss[ch]);
        end
        if (cmd == 8) begin
            m_rd[ch] = 0; m_wr[ch] = 0; m_hit[ch] = 0; m_miss[ch] = 0;
        end
    endtask

    // called 1ns after the trigger edge
    task automatic collect(input int ch, input int hold);
        int tot, e_ratio, e_lat, lat;
        bit seen;
        tot     = m_hit[ch] + m_miss[ch];
        e_ratio = (tot == 0) ? 0 : (m_hit[ch] * (1 << FRAC_W)) / tot;
        e_lat   = (tot == 0) ? 2 : FRAC_W + 3;
        seen    = 1'b0;
        lat     = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            lat = n;
            if (rpt_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("rpt_timeout", 0, 1);
            return;
        end
        chk("latency", lat, e_lat);
        chk("reads", rpt_reads, m_rd[ch]);
        chk("writes", rpt_writes, m_wr[ch]);
        chk("hits", rpt_hits, m_hit[ch]);
        chk("misses", rpt_misses, m_miss[ch]);
        chk("ratio", rpt_ratio, e_ratio);
        chk("ev_ready_done", ev_ready, 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", rpt_valid, 1);
            chk("hold_ready", ev_ready, 0);
            chk("hold_ratio", rpt_ratio, e_ratio);
            chk("hold_reads", rpt_reads, m_rd[ch]);
        end
        rpt_ready = 1'b1;
        @(posedge clk); #1;
        rpt_ready = 1'b0;
        chk("post_valid", rpt_valid, 0);
        chk("post_ready", ev_ready, 1);
    endtask

    task automatic xact(input bit ev, input int ch, input int cmd, input bit hit, input bit md,
                        input bit req, input int rch, input int hold);
        ev_valid = ev;
        ev_ch    = CH_W'(ch);
        ev_cmd   = CMD_W'(cmd);
        ev_hit   = hit;
        mode     = md;
        rpt_req  = req;
        rpt_ch   = CH_W'(rch);
        @(posedge clk); #1;
        ev_valid = 1'b0;
        rpt_req  = 1'b0;
        if (ev) model_ev(ch, cmd, hit);
        if (req) collect(rch, hold);
        else if (ev && ch < NUM_CH && cmd == 9 && !md) collect(ch, hold);
        else begin
            chk("no_rpt_valid", rpt_valid, 0);
            chk("no_rpt_ready", ev_ready, 1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_clear_all();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ev_ready", ev_ready, 1);
        chk("rst_rpt_valid", rpt_valid, 0);
        chk("rst_reads", rpt_reads, 0);
        chk("rst_ratio", rpt_ratio, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 3 read hits + 1 write miss on ch0 -> ratio 0xC0
        repeat (3) xact(1, 0, 0, 1, 0, 0, 0, 0);
        xact(1, 0, 1, 0, 0, 0, 0, 0);
        xact(0, 0, 0, 0, 0, 1, 0, 1);
        chk("t1_ratio_c0", rpt_ratio, 32'h0C0);
        // untouched ch1
        xact(0, 0, 0, 0, 0, 1, 1, 0);
        // saturation
        xact(1, 0, 8, 0, 0, 0, 0, 0);
        repeat (20) xact(1, 0, 0, 1, 0, 0, 0, 0);
        xact(0, 0, 0, 0, 0, 1, 0, 0);
        chk("t3_ratio_100", rpt_ratio, 32'h100);
        // cmd 9, normal then silent
        xact(1, 0, 9, 0, 0, 0, 0, 0);
        xact(1, 0, 9, 0, 1, 0, 0, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("silent_valid", rpt_valid, 0);
            chk("silent_ready", ev_ready, 1);
        end
        // per-channel clear
        xact(1, 0, 8, 0, 0, 0, 0, 0);
        repeat (2) xact(1, 0, 2, 0, 0, 0, 0, 0);
        repeat (2) xact(1, 1, 0, 0, 0, 0, 0, 0);
        xact(1, 1, 8, 0, 0, 0, 0, 0);
        xact(0, 0, 0, 0, 0, 1, 1, 0);
        xact(0, 0, 0, 0, 0, 1, 0, 0);
        // simultaneous cases, dropped channel
        xact(1, 3, 0, 1, 0, 0, 0, 0);
        xact(1, 3, 9, 1, 0, 0, 0, 0);
        xact(1, 0, 0, 1, 0, 1, 0, 0);
        xact(1, 1, 9, 0, 0, 1, 0, 0);
        xact(1, 0, 8, 0, 0, 1, 0, 0);
        // long backpressure
        xact(1, 2, 1, 1, 0, 0, 0, 0);
        xact(1, 2, 0, 0, 0, 0, 0, 0);
        xact(1, 2, 2, 0, 0, 1, 2, 5);

        // reset in the middle of a divide
        mode    = 1'b0;
        rpt_ch  = 2'd2;
        rpt_req = 1'b1;
        @(posedge clk); #1;
        rpt_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("div_busy", ev_ready, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", rpt_valid, 0);
        chk("rst_mid_ready", ev_ready, 1);
        chk("rst_mid_reads", rpt_reads, 0);
        chk("rst_mid_ratio", rpt_ratio, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear_all();
        xact(0, 0, 0, 0, 0, 1, 2, 0);

        for (int it = 0; it < 400; it++) begin
            int ch, cmd, rch, hold;
            bit ev, hit, md, req;
            ev   = ($urandom % 8) != 0;
            ch   = $urandom % 4;
            cmd  = (($urandom % 16) < 10) ? ($urandom % 3) : ($urandom % 12);
            hit  = $urandom % 2;
            md   = $urandom % 2;
            req  = ($urandom % 6) == 0;
            rch  = $urandom % NUM_CH;
            hold = $urandom % 3;
            xact(ev, ch, cmd, hit, md, req, rch, hold);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
